rf_commit_ctrl: RTL and testbench

Commit sequencer between the reorder buffer head and the RegFile commit port. Pops retiring entries from the ROB with a valid/ready handshake and drives `commit_en`/`commit_addr`/`commit_data` one cycle later. On an excepting entry or an external flush request, it pulses `commit_restore` so RegFile drops all outstanding ref IDs, then holds retirement for a drain window. It also keeps a retired-instruction counter for debug and performance use.

---
 rtl/rf_commit_ctrl.sv | 158 +++++++++++++++
 tb/tb_rf_commit_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_commit_ctrl.sv
// ---------------------------------------------------------------------------
// rf_commit_ctrl
//
// Purpose:
//   Commit sequencer between the reorder-buffer head and the RegFile commit
//   port. It pops retiring entries from the ROB with a valid/ready handshake
//   and drives the RegFile commit port one cycle after each accept.
//   An excepting entry, or an external flush request, produces a one-cycle
//   restore/flush pulse. Retirement is then held off for a drain window of
//   DRAIN_CYCLES cycles. A 32-bit counter tracks retired entries.
//
// Parameters:
//   DRAIN_CYCLES   cycles spent in DRAIN after the restore pulse (1..15)
//   ADDR_W         register address width (RegFile address bus)
//   DATA_W         data width (RegFile data bus)
//
// Ports:
//   clk             clock
//   rst             synchronous, active-low reset
//   rob_valid       ROB head entry is complete and retirable
//   rob_ready       head entry is accepted this cycle (when rob_valid)
//   rob_dest_en     head entry writes a register
//   rob_dest_addr   destination register of head entry
//   rob_data        result value of head entry
//   rob_exc         head entry raised an exception
//   flush_req       external flush request (level, sampled every cycle)
//   commit_en       RegFile write enable
//   commit_restore  RegFile: drop all outstanding ref IDs
//   commit_addr     RegFile write address
//   commit_data     RegFile write data
//   flush           one-cycle pulse to front end / ROB
//   busy            controller is in RESTORE or DRAIN
//   retire_count    number of accepted non-excepting entries (wraps)
// ---------------------------------------------------------------------------
module rf_commit_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rob_valid,
    output logic              rob_ready,
    input  logic              rob_dest_en,
    input  logic [ADDR_W-1:0] rob_dest_addr,
    input  logic [DATA_W-1:0] rob_data,
    input  logic              rob_exc,
    input  logic              flush_req,
    output logic              commit_en,
    output logic              commit_restore,
    output logic [ADDR_W-1:0] commit_addr,
    output logic [DATA_W-1:0] commit_data,
    output logic              flush,
    output logic              busy,
    output logic [31:0]       retire_count
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_RESTORE = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

    logic [1:0]        r_state;
    logic [3:0]        r_drain_cnt;
    logic              r_commit_en;
    logic              r_commit_restore;
    logic [ADDR_W-1:0] r_commit_addr;
    logic [DATA_W-1:0] r_commit_data;
    logic              r_flush;
    logic [31:0]       r_retire_count;

    logic              w_run;
    logic              w_accept;
    logic              w_dest_nonzero;

    // Ready is a function of state and flush_req only, never of rob_valid,
    // so the ROB may legally wait for ready before raising valid.
    assign w_run          = (r_state == ST_RUN);
    assign rob_ready      = w_run && !flush_req;
    assign w_accept       = rob_valid && rob_ready;
    assign w_dest_nonzero = (rob_dest_addr != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state          <= ST_RUN;
            r_drain_cnt      <= '0;
            r_commit_en      <= 1'b0;
            r_commit_restore <= 1'b0;
            r_commit_addr    <= '0;
            r_commit_data    <= '0;
            r_flush          <= 1'b0;
            r_retire_count   <= '0;
        end else begin
            // Commit and restore outputs are single-cycle pulses; they fall
            // back to zero unless this cycle produces a new one.
            r_commit_en      <= 1'b0;
            r_commit_restore <= 1'b0;
            r_commit_addr    <= '0;
            r_commit_data    <= '0;
            r_flush          <= 1'b0;

            case (r_state)
                ST_RUN: begin
                    if (flush_req) begin
                        // flush_req masks ready, so no entry is taken here.
                        r_state          <= ST_RESTORE;
                        r_commit_restore <= 1'b1;
                        r_flush          <= 1'b1;
                    end else if (w_accept) begin
                        if (rob_exc) begin
                            r_state          <= ST_RESTORE;
                            r_commit_restore <= 1'b1;
                            r_flush          <= 1'b1;
                        end else begin
                            // Writes to register 0 are suppressed but the
                            // entry still retires and is counted.
                            r_commit_en    <= rob_dest_en && w_dest_nonzero;
                            r_commit_addr  <= rob_dest_addr;
                            r_commit_data  <= rob_data;
                            r_retire_count <= r_retire_count + 32'd1;
                        end
                    end
                end

                ST_RESTORE: begin
                    r_drain_cnt <= DRAIN_LOAD;
                    r_state     <= ST_DRAIN;
                end

                ST_DRAIN: begin
                    // A flush seen while draining restarts the window; the
                    // RegFile has already been restored so no second pulse.
                    if (flush_req) begin
                        r_drain_cnt <= DRAIN_LOAD;
                    end else if (r_drain_cnt <= 4'd1) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 4'd1;
                    end
                end

                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign commit_en      = r_commit_en;
    assign commit_restore = r_commit_restore;
    assign commit_addr    = r_commit_addr;
    assign commit_data    = r_commit_data;
    assign flush          = r_flush;
    assign busy           = !w_run;
    assign retire_count   = r_retire_count;

endmodule

// File: tb/tb_rf_commit_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rf_commit_ctrl
//
// Purpose:
//   Directed self-checking bench for rf_commit_ctrl with DRAIN_CYCLES=2.
//   Inputs change 1 time unit after each rising edge; outputs are checked
//   2 time units after the edge, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_rf_commit_ctrl;

    logic        clk;
    logic        rst;
    logic        rob_valid;
    logic        rob_ready;
    logic        rob_dest_en;
    logic [4:0]  rob_dest_addr;
    logic [31:0] rob_data;
    logic        rob_exc;
    logic        flush_req;
    logic        commit_en;
    logic        commit_restore;
    logic [4:0]  commit_addr;
    logic [31:0] commit_data;
    logic        flush;
    logic        busy;
    logic [31:0] retire_count;

    int n_assert;
    int n_fail;

    rf_commit_ctrl #(
        .DRAIN_CYCLES (2),
        .ADDR_W       (5),
        .DATA_W       (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rob_valid      (rob_valid),
        .rob_ready      (rob_ready),
        .rob_dest_en    (rob_dest_en),
        .rob_dest_addr  (rob_dest_addr),
        .rob_data       (rob_data),
        .rob_exc        (rob_exc),
        .flush_req      (flush_req),
        .commit_en      (commit_en),
        .commit_restore (commit_restore),
        .commit_addr    (commit_addr),
        .commit_data    (commit_data),
        .flush          (flush),
        .busy           (busy),
        .retire_count   (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 unit after the next rising edge (input drive point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic de, input logic [4:0] a,
                         input logic [31:0] d, input logic e, input logic fr);
        rob_valid     = v;
        rob_dest_en   = de;
        rob_dest_addr = a;
        rob_data      = d;
        rob_exc       = e;
        flush_req     = fr;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

        // ---------------- reset state ----------------
        tick(); idle();
        tick(); idle();
        chk("rst_commit_en",  32'(commit_en), 32'd0);
        chk("rst_restore",    32'(commit_restore), 32'd0);
        chk("rst_flush",      32'(flush), 32'd0);
        chk("rst_busy",       32'(busy), 32'd0);
        chk("rst_retire",     retire_count, 32'd0);
        chk("rst_ready",      32'(rob_ready), 32'd1);
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        chk("rst_ready_fr",   32'(rob_ready), 32'd0);
        idle();
        rst = 1'b1;

        // ---------------- single commit ----------------
        tick(); drive(1'b1, 1'b1, 5'd1, 32'h12345678, 1'b0, 1'b0);
        chk("t1_ready", 32'(rob_ready), 32'd1);
        tick(); idle();
        chk("t1_en",     32'(commit_en), 32'd1);
        chk("t1_addr",   32'(commit_addr), 32'd1);
        chk("t1_data",   commit_data, 32'h12345678);
        chk("t1_retire", retire_count, 32'd1);
        tick(); idle();
        chk("t1_en_off", 32'(commit_en), 32'd0);

        // ---------------- back-to-back ----------------
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i > 1) begin
                chk("t2_en",   32'(commit_en), 32'd1);
                chk("t2_addr", 32'(commit_addr), 32'(i - 1));
                chk("t2_data", commit_data, 32'(i - 1) * 32'h11);
            end
            drive(1'b1, 1'b1, 5'(i), 32'(i) * 32'h11, 1'b0, 1'b0);
            chk("t2_ready", 32'(rob_ready), 32'd1);
        end
        tick(); idle();
        chk("t2_en_last",   32'(commit_en), 32'd1);
        chk("t2_addr_last", 32'(commit_addr), 32'd4);
        chk("t2_data_last", commit_data, 32'h44);
        chk("t2_retire",    retire_count, 32'd5);
        tick(); idle();
        chk("t2_en_off", 32'(commit_en), 32'd0);

        // ---------------- zero register and no-dest ----------------
        tick(); drive(1'b1, 1'b1, 5'd0, 32'hffffffff, 1'b0, 1'b0);
        tick(); drive(1'b1, 1'b0, 5'd3, 32'hdeadbeef, 1'b0, 1'b0);
        chk("t3_en_r0", 32'(commit_en), 32'd0);
        tick(); idle();
        chk("t3_en_nodest", 32'(commit_en), 32'd0);
        chk("t3_retire",    retire_count, 32'd7);

        // ---------------- exception ----------------
        tick(); drive(1'b1, 1'b1, 5'd5, 32'h55, 1'b1, 1'b0);       // N
        chk("t4_ready_n", 32'(rob_ready), 32'd1);
        tick(); drive(1'b1, 1'b1, 5'd6, 32'h66, 1'b0, 1'b0);       // N+1
        chk("t4_restore", 32'(commit_restore), 32'd1);
        chk("t4_flush",   32'(flush), 32'd1);
        chk("t4_en",      32'(commit_en), 32'd0);
        chk("t4_busy1",   32'(busy), 32'd1);
        chk("t4_ready1",  32'(rob_ready), 32'd0);
        chk("t4_retire1", retire_count, 32'd7);
        tick(); drive(1'b1, 1'b1, 5'd6, 32'h66, 1'b0, 1'b0);       // N+2
        chk("t4_restore2", 32'(commit_restore), 32'd0);
        chk("t4_flush2",   32'(flush), 32'd0);
        chk("t4_ready2",   32'(rob_ready), 32'd0);
        chk("t4_busy2",    32'(busy), 32'd1);
        tick(); drive(1'b1, 1'b1, 5'd6, 32'h66, 1'b0, 1'b0);       // N+3
        chk("t4_ready3",   32'(rob_ready), 32'd0);
        chk("t4_en3",      32'(commit_en), 32'd0);
        chk("t4_restore3", 32'(commit_restore), 32'd0);
        tick(); idle();                                            // N+4
        chk("t4_ready4",  32'(rob_ready), 32'd1);
        chk("t4_busy4",   32'(busy), 32'd0);
        chk("t4_en4",     32'(commit_en), 32'd0);
        chk("t4_retire4", retire_count, 32'd7);

        // ---------------- flush_req with valid head ----------------
        tick(); drive(1'b1, 1'b1, 5'd2, 32'haa, 1'b0, 1'b0);       // M
        tick(); drive(1'b1, 1'b1, 5'd3, 32'hbb, 1'b0, 1'b1);       // M+1
        chk("t5_en",     32'(commit_en), 32'd1);
        chk("t5_addr",   32'(commit_addr), 32'd2);
        chk("t5_data",   commit_data, 32'haa);
        chk("t5_ready",  32'(rob_ready), 32'd0);
        chk("t5_retire", retire_count, 32'd8);
        tick(); idle();                                            // M+2
        chk("t5_restore", 32'(commit_restore), 32'd1);
        chk("t5_flush",   32'(flush), 32'd1);
        chk("t5_en2",     32'(commit_en), 32'd0);
        chk("t5_retire2", retire_count, 32'd8);
        tick(); drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);        // M+3
        chk("t5_restore3", 32'(commit_restore), 32'd0);
        chk("t5_busy3",    32'(busy), 32'd1);
        tick(); idle();                                            // M+4
        chk("t5_restore4", 32'(commit_restore), 32'd0);
        chk("t5_flush4",   32'(flush), 32'd0);
        chk("t5_busy4",    32'(busy), 32'd1);
        tick(); idle();                                            // M+5
        chk("t5_busy5",    32'(busy), 32'd1);
        chk("t5_ready5",   32'(rob_ready), 32'd0);
        chk("t5_restore5", 32'(commit_restore), 32'd0);
        tick(); idle();                                            // M+6
        chk("t5_busy6",  32'(busy), 32'd0);
        chk("t5_ready6", 32'(rob_ready), 32'd1);

        // ---------------- reset mid-drain ----------------
        tick(); drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);        // P
        tick(); idle();                                            // P+1
        chk("t6_restore1", 32'(commit_restore), 32'd1);
        tick(); idle();                                            // P+2
        chk("t6_busy2", 32'(busy), 32'd1);
        rst = 1'b0;
        tick(); idle();                                            // P+3
        chk("t6_busy3",    32'(busy), 32'd0);
        chk("t6_retire3",  retire_count, 32'd0);
        chk("t6_restore3", 32'(commit_restore), 32'd0);
        chk("t6_ready3",   32'(rob_ready), 32'd1);
        rst = 1'b1;
        tick(); idle();                                            // P+4
        chk("t6_busy4",    32'(busy), 32'd0);
        chk("t6_restore4", 32'(commit_restore), 32'd0);
        chk("t6_flush4",   32'(flush), 32'd0);

        // ---------------- reset during pending restore pulse ----------------
        tick(); drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);        // Q
        rst = 1'b0;
        tick(); idle();                                            // Q+1
        chk("t7_restore", 32'(commit_restore), 32'd0);
        chk("t7_flush",   32'(flush), 32'd0);
        chk("t7_busy",    32'(busy), 32'd0);
        rst = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
